// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone UART: register map, status bit positions,
// the TX/RX state encoding and the divisor floor.
package wb_uart_pkg;

    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_TXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    localparam int ST_RX_VALID   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_TX_ACTIVE  = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_FRAME_ERR  = 4;

    localparam logic [15:0] MIN_DIV = 16'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_e;

    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/wb_uart_rx.sv
// 8N1 receiver: input synchronizer, falling-edge start detect, mid-bit sampling.
// Emits the byte with a one-cycle done pulse and the stop-bit error flag.
module wb_uart_rx
    import wb_uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] div_i,
    input  logic        rx_i,
    output logic [7:0]  data_o,
    output logic        done_o,
    output logic        frame_err_o
);

    logic        sync1_reg;
    logic        sync2_reg;
    logic        prev_reg;
    uart_state_e state_reg;
    logic [15:0] cnt_reg;
    logic [2:0]  bit_reg;
    logic [7:0]  shift_reg;
    logic [16:0] half_div;

    // Widened so the largest divisor cannot wrap when rounding the half period.
    assign half_div = ({1'b0, div_i} + 17'd1) >> 1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
            prev_reg    <= 1'b1;
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
            data_o      <= '0;
            done_o      <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            sync1_reg <= rx_i;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            done_o    <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (prev_reg && !sync2_reg) begin
                        state_reg <= S_START;
                        cnt_reg   <= half_div[15:0] - 16'd1;
                    end
                end
                S_START: begin
                    if (cnt_reg != 16'd0) begin
                        cnt_reg <= cnt_reg - 16'd1;
                    end else if (sync2_reg) begin
                        state_reg <= S_IDLE;
                    end else begin
                        state_reg <= S_DATA;
                        cnt_reg   <= div_i;
                        bit_reg   <= '0;
                    end
                end
                S_DATA: begin
                    if (cnt_reg != 16'd0) begin
                        cnt_reg <= cnt_reg - 16'd1;
                    end else begin
                        shift_reg <= {sync2_reg, shift_reg[7:1]};
                        cnt_reg   <= div_i;
                        if (bit_reg == 3'd7) begin
                            state_reg <= S_STOP;
                        end else begin
                            bit_reg <= bit_reg + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (cnt_reg != 16'd0) begin
                        cnt_reg <= cnt_reg - 16'd1;
                    end else begin
                        data_o      <= shift_reg;
                        done_o      <= 1'b1;
                        frame_err_o <= ~sync2_reg;
                        state_reg   <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/wb_uart_slave.sv
// Wishbone pipelined slave with a four-register UART: bus decode, register file,
// TX holding register plus shifter, and the receiver sub-module.
module wb_uart_slave
    import wb_uart_pkg::*;
#(
    parameter int AW          = 2,
    parameter int DW          = 32,
    parameter int DEFAULT_DIV = 867
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [DW-1:0]   wb_data_i,
    input  logic [DW/8-1:0] wb_sel_i,
    output logic            wb_stall_o,
    output logic            wb_ack_o,
    output logic [DW-1:0]   wb_data_o,
    output logic            uart_tx_o,
    input  logic            uart_rx_i
);

    logic [1:0]    reg_sel;
    logic          req, wr_tx, wr_stat, wr_baud, rd_rx;
    logic [DW-1:0] rd_data;
    logic [15:0]   baud_wr;

    logic          ack_reg;
    logic [DW-1:0] rdata_reg;
    logic [15:0]   baud_reg;
    logic [7:0]    rx_data_reg;
    logic          rx_valid_reg, overrun_reg, frame_err_reg;
    logic [7:0]    tx_hold_reg;
    logic          tx_full_reg;

    uart_state_e   tx_state_reg;
    logic [15:0]   tx_cnt_reg;
    logic [2:0]    tx_bit_reg;
    logic [7:0]    tx_shift_reg;
    logic          tx_reg;
    logic          tx_load;

    logic [7:0]    rx_byte;
    logic          rx_done, rx_ferr;

    assign reg_sel = wb_addr_i[1:0];
    assign req     = wb_cyc_i & wb_stb_i;
    assign wr_tx   = req & wb_we_i & (reg_sel == REG_TXDATA) & wb_sel_i[0];
    assign wr_stat = req & wb_we_i & (reg_sel == REG_STATUS);
    assign wr_baud = req & wb_we_i & (reg_sel == REG_BAUD);
    assign rd_rx   = req & ~wb_we_i & (reg_sel == REG_RXDATA);

    for (genvar gi = 0; gi < 2; gi++) begin : g_baud_lane
        assign baud_wr[gi*8 +: 8] = wb_sel_i[gi] ? wb_data_i[gi*8 +: 8] : baud_reg[gi*8 +: 8];
    end

    logic unused_bits;
    assign unused_bits = ^{wb_data_i[DW-1:16], wb_sel_i[DW/8-1:2]};

    // Shifter takes the held byte when idle, or straight out of a finished stop bit.
    assign tx_load = tx_full_reg &&
                     ((tx_state_reg == S_IDLE) ||
                      (tx_state_reg == S_STOP && tx_cnt_reg == 16'd0));

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_RXDATA: rd_data[8:0] = {rx_valid_reg, rx_data_reg};
            REG_STATUS: begin
                rd_data[ST_RX_VALID]   = rx_valid_reg;
                rd_data[ST_TX_FULL]    = tx_full_reg;
                rd_data[ST_TX_ACTIVE]  = (tx_state_reg != S_IDLE);
                rd_data[ST_RX_OVERRUN] = overrun_reg;
                rd_data[ST_FRAME_ERR]  = frame_err_reg;
            end
            REG_BAUD:   rd_data[15:0] = baud_reg;
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_reg       <= 1'b0;
            rdata_reg     <= '0;
            baud_reg      <= 16'(DEFAULT_DIV);
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            tx_hold_reg   <= '0;
            tx_full_reg   <= 1'b0;
        end else begin
            ack_reg   <= req;
            rdata_reg <= (req && !wb_we_i) ? rd_data : '0;

            if (tx_load) tx_full_reg <= 1'b0;
            if (wr_tx && (!tx_full_reg || tx_load)) begin
                tx_hold_reg <= wb_data_i[7:0];
                tx_full_reg <= 1'b1;
            end

            if (wr_baud) baud_reg <= clamp_div(baud_wr);

            if (wr_stat && wb_data_i[ST_RX_OVERRUN]) overrun_reg   <= 1'b0;
            if (wr_stat && wb_data_i[ST_FRAME_ERR])  frame_err_reg <= 1'b0;
            if (rd_rx) rx_valid_reg <= 1'b0;

            // A store wins over a same-cycle read or clear of the same flag.
            if (rx_done) begin
                rx_data_reg  <= rx_byte;
                rx_valid_reg <= 1'b1;
                if (rx_valid_reg && !rd_rx) overrun_reg <= 1'b1;
                if (rx_ferr) frame_err_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state_reg <= S_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_reg       <= 1'b1;
        end else begin
            case (tx_state_reg)
                S_IDLE: begin
                    if (tx_load) begin
                        tx_shift_reg <= tx_hold_reg;
                        tx_reg       <= 1'b0;
                        tx_cnt_reg   <= baud_reg;
                        tx_state_reg <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt_reg != 16'd0) begin
                        tx_cnt_reg <= tx_cnt_reg - 16'd1;
                    end else begin
                        tx_reg       <= tx_shift_reg[0];
                        tx_cnt_reg   <= baud_reg;
                        tx_bit_reg   <= '0;
                        tx_state_reg <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tx_cnt_reg != 16'd0) begin
                        tx_cnt_reg <= tx_cnt_reg - 16'd1;
                    end else begin
                        tx_cnt_reg <= baud_reg;
                        if (tx_bit_reg == 3'd7) begin
                            tx_reg       <= 1'b1;
                            tx_state_reg <= S_STOP;
                        end else begin
                            tx_reg       <= tx_shift_reg[1];
                            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                            tx_bit_reg   <= tx_bit_reg + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (tx_cnt_reg != 16'd0) begin
                        tx_cnt_reg <= tx_cnt_reg - 16'd1;
                    end else if (tx_load) begin
                        tx_shift_reg <= tx_hold_reg;
                        tx_reg       <= 1'b0;
                        tx_cnt_reg   <= baud_reg;
                        tx_state_reg <= S_START;
                    end else begin
                        tx_state_reg <= S_IDLE;
                    end
                end
                default: tx_state_reg <= S_IDLE;
            endcase
        end
    end

    wb_uart_rx u_rx (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .div_i       (baud_reg),
        .rx_i        (uart_rx_i),
        .data_o      (rx_byte),
        .done_o      (rx_done),
        .frame_err_o (rx_ferr)
    );

    assign wb_stall_o = 1'b0;
    assign wb_ack_o   = ack_reg;
    assign wb_data_o  = rdata_reg;
    assign uart_tx_o  = tx_reg;

endmodule

// File: tb/tb_wb_uart_slave.sv
// Directed bench for wb_uart_slave: bus timing, register map, TX framing,
// RX reception, overrun, framing error, glitch rejection and mid-frame reset.
module tb_wb_uart_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  sel = '0;
    logic        stall, ack, tx;
    logic [31:0] rdata;
    logic        rx = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wb_uart_slave #(.AW(2), .DW(32), .DEFAULT_DIV(867)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_addr_i  (addr),
        .wb_data_i  (wdata),
        .wb_sel_i   (sel),
        .wb_stall_o (stall),
        .wb_ack_o   (ack),
        .wb_data_o  (rdata),
        .uart_tx_o  (tx),
        .uart_rx_i  (rx)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic acked);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d; sel = s;
        @(posedge clk); #1;
        acked = ack;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        $display("wr addr=%0d data=%h sel=%b ack=%0d", a, d, s, acked);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic acked);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a; sel = 4'hF;
        @(posedge clk); #1;
        acked = ack;
        d = rdata;
        cyc = 1'b0; stb = 1'b0;
        $display("rd addr=%0d data=%h ack=%0d", a, d, acked);
    endtask

    task automatic wait_until(input int t);
        while (cyc_cnt < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            rx = f[k];
            repeat (16) @(negedge clk);
        end
        rx = 1'b1;
        repeat (20) @(negedge clk);
        $display("rx frame byte=%h stop=%0d", b, stop_bit);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic a;
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        checks++;
        if (ack !== 1'b0 || rdata !== 32'h0 || stall !== 1'b0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_outputs: ack=%b data=%h stall=%b tx=%b required 0/0/0/1", ack, rdata, stall, tx);
        end
        rst = 1'b0;
        bus_read(2'd3, d, a);
        checks++;
        if (a !== 1'b1 || d !== 32'h363) begin
            failures++;
            $display("FAIL reset_baud: ack=%b data=%h required ack=1 data=00000363", a, d);
        end
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL ack_one_cycle: ack=%b data=%h required 0/0", ack, rdata);
        end
        bus_read(2'd2, d, a);
        checks++;
        if (a !== 1'b1 || d !== 32'h0) begin
            failures++;
            $display("FAIL reset_status: ack=%b data=%h required ack=1 data=0", a, d);
        end
    endtask

    task automatic test_baud();
        logic [31:0] d;
        logic a;
        logic [31:0] wr_v [4] = '{32'h0000_1234, 32'hFFFF_5678, 32'h0000_0002, 32'h0000_000F};
        logic [3:0]  wr_s [4] = '{4'hF, 4'h1, 4'hF, 4'h3};
        logic [31:0] exp_v [4] = '{32'h0000_1234, 32'h0000_1278, 32'h0000_0003, 32'h0000_000F};
        for (int i = 0; i < 4; i++) begin
            bus_write(2'd3, wr_v[i], wr_s[i], a);
            bus_read(2'd3, d, a);
            checks++;
            if (a !== 1'b1 || d !== exp_v[i]) begin
                failures++;
                $display("FAIL baud_%0d: ack=%b data=%h required %h", i, a, d, exp_v[i]);
            end
        end
        bus_read(2'd1, d, a);
        checks++;
        if (a !== 1'b1 || d !== 32'h0) begin
            failures++;
            $display("FAIL txdata_read: ack=%b data=%h required 0", a, d);
        end
    endtask

    task automatic test_tx();
        logic [31:0] d;
        logic a;
        logic [9:0] frame;
        int e;
        frame = {1'b1, 8'hA5, 1'b0};
        bus_write(2'd1, 32'h0000_00A5, 4'h1, a);
        e = cyc_cnt;
        checks++;
        if (a !== 1'b1 || tx !== 1'b1) begin
            failures++;
            $display("FAIL tx_write: ack=%b tx=%b required 1/1", a, tx);
        end
        bus_read(2'd2, d, a);
        checks++;
        if (d !== 32'h2 || tx !== 1'b0) begin
            failures++;
            $display("FAIL tx_full_set: status=%h tx=%b required 00000002/0", d, tx);
        end
        bus_read(2'd2, d, a);
        checks++;
        if (d !== 32'h4) begin
            failures++;
            $display("FAIL tx_full_clear: status=%h required 00000004", d);
        end
        for (int k = 0; k < 10; k++) begin
            wait_until(e + 1 + 16 * k + 8);
            checks++;
            if (tx !== frame[k]) begin
                failures++;
                $display("FAIL tx_bit_%0d: tx=%b required %b", k, tx, frame[k]);
            end
        end
        wait_until(e + 1 + 160);
        bus_read(2'd2, d, a);
        checks++;
        if (d !== 32'h0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL tx_done: status=%h tx=%b required 0/1", d, tx);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic a;
        logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};
        logic [9:0] frame;
        int acks;
        int e;
        acks = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 2'd1; sel = 4'h1; wdata = {24'h0, bytes[0]};
        @(posedge clk); #1;
        e = cyc_cnt;
        for (int i = 1; i < 3; i++) begin
            acks += int'(ack);
            wdata = {24'h0, bytes[i]};
            @(posedge clk); #1;
        end
        acks += int'(ack);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        $display("b2b writes 11/22/33 acks=%0d trailing_ack=%b", acks, ack);
        checks++;
        if (acks != 3 || ack !== 1'b0) begin
            failures++;
            $display("FAIL b2b_acks: acks=%0d trailing=%b required 3/0", acks, ack);
        end
        for (int f = 0; f < 2; f++) begin
            frame = {1'b1, bytes[f], 1'b0};
            for (int k = 0; k < 10; k++) begin
                wait_until(e + 1 + 160 * f + 16 * k + 8);
                checks++;
                if (tx !== frame[k]) begin
                    failures++;
                    $display("FAIL b2b_f%0d_bit%0d: tx=%b required %b", f, k, tx, frame[k]);
                end
            end
            if (f == 0) begin
                wait_until(e + 1 + 159);
                checks++;
                if (tx !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_stop_end: tx=%b required 1", tx);
                end
                wait_until(e + 1 + 160);
                checks++;
                if (tx !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_no_gap: tx=%b required 0", tx);
                end
            end
        end
        wait_until(e + 1 + 320);
        bus_read(2'd2, d, a);
        checks++;
        if (d !== 32'h0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL b2b_drop_third: status=%h tx=%b required 0/1", d, tx);
        end
    endtask

    task automatic test_rx();
        logic [31:0] d;
        logic a;
        send_rx(8'h3C, 1'b1);
        bus_read(2'd0, d, a);
        checks++;
        if (a !== 1'b1 || d !== 32'h13C) begin
            failures++;
            $display("FAIL rx_first_read: ack=%b data=%h required 0000013c", a, d);
        end
        bus_read(2'd0, d, a);
        checks++;
        if (d !== 32'h03C) begin
            failures++;
            $display("FAIL rx_second_read: data=%h required 0000003c", d);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        logic a;
        send_rx(8'h5A, 1'b1);
        send_rx(8'hC3, 1'b1);
        bus_read(2'd2, d, a);
        checks++;
        if (d !== 32'h09) begin
            failures++;
            $display("FAIL overrun_status: status=%h required 00000009", d);
        end
        bus_read(2'd0, d, a);
        checks++;
        if (d !== 32'h1C3) begin
            failures++;
            $display("FAIL overrun_data: data=%h required 000001c3", d);
        end
        bus_write(2'd2, 32'h08, 4'hF, a);
        bus_read(2'd2, d, a);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL overrun_clear: status=%h required 0", d);
        end
    endtask

    task automatic test_frame_err();
        logic [31:0] d;
        logic a;
        send_rx(8'h81, 1'b0);
        bus_read(2'd2, d, a);
        checks++;
        if (d !== 32'h11) begin
            failures++;
            $display("FAIL frame_err_status: status=%h required 00000011", d);
        end
        bus_read(2'd0, d, a);
        checks++;
        if (d !== 32'h181) begin
            failures++;
            $display("FAIL frame_err_data: data=%h required 00000181", d);
        end
        bus_write(2'd2, 32'h10, 4'hF, a);
        bus_read(2'd2, d, a);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL frame_err_clear: status=%h required 0", d);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic a;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        bus_read(2'd2, d, a);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL glitch_reject: status=%h required 0", d);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        logic a;
        bus_write(2'd1, 32'h0000_0000, 4'h1, a);
        repeat (30) @(posedge clk); #1;
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL midframe_low: tx=%b required 0", tx);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (tx !== 1'b1) begin
            failures++;
            $display("FAIL midframe_reset_tx: tx=%b required 1", tx);
        end
        bus_read(2'd2, d, a);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL midframe_reset_status: status=%h required 0", d);
        end
        bus_read(2'd3, d, a);
        checks++;
        if (d !== 32'h363) begin
            failures++;
            $display("FAIL midframe_reset_baud: data=%h required 00000363", d);
        end
    endtask

    initial begin
        test_reset();
        test_baud();
        test_tx();
        test_back_to_back();
        test_rx();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_uart_slave.md
# wb_uart_slave

Wishbone pipelined-mode slave UART peripheral. It is the responder at the far end of the core-side Wishbone master bridge. It decodes the four-word register window (AW=2) and returns a single-cycle ack for every accepted request. It also contains an 8N1 transmitter and receiver with a programmable bit divisor, and drives/samples the board UART pins.

## Interface
Parameters:
- AW, 2, Wishbone word-address width (4 registers)
- DW, 32, Wishbone data width
- DEFAULT_DIV, 867, reset value of BAUD divisor (bit period = DIV+1 clocks; 100 MHz / 115200)

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- wb_cyc_i  in  1  bus cycle active
- wb_stb_i  in  1  request strobe
- wb_we_i  in  1  1 = write
- wb_addr_i  in  AW  word address
- wb_data_i  in  DW  write data
- wb_sel_i  in  DW/8  byte lanes
- wb_stall_o  out  1  tied 0; every request is accepted
- wb_ack_o  out  1  one-cycle acknowledge
- wb_data_o  out  DW  read data, valid with ack, 0 otherwise
- uart_tx_o  out  1  serial out, idle high
- uart_rx_i  in  1  serial in, asynchronous

## Operation
- A request is accepted on a clock edge where wb_cyc_i & wb_stb_i are both 1. Each accepted request gets exactly one ack.
- Register map (word address):
  - 0 RXDATA, read-only:
    - [7:0] last received byte, [8] rx_valid.
    - A read clears rx_valid.
  - 1 TXDATA, write-only:
    - When wb_sel_i[0] = 1, byte [7:0] is loaded into the TX holding register.
    - The write is dropped, but still acked, if the holding register is already full.
    - Reads return 0.
  - 2 STATUS:
    - Read: [0] rx_valid, [1] tx_full (holding occupied), [2] tx_active (shifter busy), [3] rx_overrun, [4] frame_err.
    - Write: a 1 in bit 3 or bit 4 clears the matching bit; writing 0 leaves it unchanged.
  - 3 BAUD:
    - [15:0] divisor, read/write; only byte lanes 0–1 are honoured.
    - Written values below 3 are stored as 3.
- TX:
  - When the shifter is idle and the holding register is full, the shifter takes the byte and clears the holding register.
  - Frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts DIV+1 cycles.
- RX:
  - uart_rx_i passes through a 2-flop synchronizer.
  - A falling edge while the receiver is idle starts a frame.
  - The start bit is re-checked at (DIV+1)/2 cycles. If it reads 1, the event is a glitch and the receiver returns to idle.
  - Data bits are sampled every DIV+1 cycles after that, then the stop bit.
  - At stop-bit sampling the byte is stored into RXDATA and rx_valid is set. If the stop bit is 0, frame_err is also set; the byte is still stored.
  - If rx_valid is already 1 when a new byte is stored, the new byte overwrites the old one and rx_overrun is set.
- Receiver states: IDLE → START → DATA(8) → STOP → IDLE.
- Transmitter states: IDLE → START → DATA(8) → STOP → IDLE.

## Timing
- Reset values:
  - wb_ack_o = 0, wb_data_o = 0, wb_stall_o = 0
  - uart_tx_o = 1
  - BAUD = DEFAULT_DIV
  - All status bits = 0; both state machines in IDLE.
- Ack and read data are registered: request accepted at edge N → wb_ack_o = 1 with read data during cycle N+1 only.
- Back-to-back requests on consecutive cycles produce consecutive acks.
- A write to TXDATA takes effect at edge N. With the shifter idle, the shifter loads at edge N+1 and uart_tx_o goes low at edge N+1. The full frame lasts 10·(DIV+1) cycles.
- Back-to-back bytes: with the holding register full, the next start bit begins on the cycle immediately after the previous stop bit ends; there is no idle gap.
- RX latency: rx_valid rises one cycle after the stop-bit sample point.
- Simultaneous events:
  - RXDATA read in the same cycle as a new byte store: the new byte wins, rx_valid stays 1, overrun is not set. The ack returns the old byte.
  - STATUS write-clear in the same cycle as a set of the same bit: the set wins.
  - TXDATA write in the same cycle the shifter empties a full holding register: the write is accepted.
- A BAUD write mid-frame takes effect at the next bit boundary. The current bit completes with the old divisor.
- Reset mid-frame: uart_tx_o returns to 1 on the next edge, the receiver goes to IDLE, and the partial byte is discarded.

## Structure
- The package wb_uart_pkg holds:
  - register word addresses (RXDATA=0, TXDATA=1, STATUS=2, BAUD=3)
  - status bit indices
  - the state-machine enum shared by TX and RX
  - minimum divisor constant 3
- Sub-module wb_uart_rx contains the synchronizer, the RX state machine and the bit counter. It outputs a byte, a one-cycle done pulse and frame_err.
- The TX shifter, the register file and the bus logic stay in the top level.

## Test plan
- Reset, then read BAUD → ack in cycle N+1 with data 0x363; read STATUS → 0; uart_tx_o = 1.
- Write BAUD=15, then write TXDATA=0xA5 → uart_tx_o shows bits 0,1,0,1,0,0,1,0,1,1, each 16 cycles long. tx_full clears one cycle after the write.
- Write 0x11 then 0x22 then 0x33 on consecutive cycles → 0x11 and 0x22 are sent with no gap, 0x33 is dropped, and 3 acks are returned.
- With DIV=15, drive 0x3C serially on uart_rx_i → RXDATA reads 0x13C; the next RXDATA read returns 0x03C.
- Send two bytes without reading RXDATA → STATUS bit 3 = 1 and RXDATA holds the second byte. Writing STATUS 0x08 clears bit 3.
- Hold the stop bit low → STATUS bit 4 = 1 and the byte is stored. A 4-cycle low glitch on uart_rx_i → no byte is received.
